// File: rtl/adc_event_packer.sv
// Timestamps valid ADC samples and, on a threshold crossing, writes a pre/post-trigger window
// of {timestamp, sample} words into the preprocessing FIFO.
module adc_event_packer #(
  parameter int unsigned PRE_SAMPLES     = 4,
  parameter int unsigned POST_SAMPLES    = 12,
  parameter int unsigned HOLDOFF_SAMPLES = 8
) (
  input  logic        clk210_p,
  input  logic        reset_p,
  input  logic [15:0] adc_data_p,
  input  logic        adc_valid_p,
  input  logic [15:0] threshold_p,
  input  logic        enable_p,
  input  logic        fifo_adc_full_p,
  output logic        fifo_adc_wr_en_p,
  output logic [79:0] fifo_adc_din_p,
  output logic        busy_p,
  output logic        overflow_p,
  output logic [15:0] drop_count_p,
  output logic [15:0] event_count_p
);

  localparam int unsigned CntW   = 11;
  localparam int unsigned WinLen = PRE_SAMPLES + POST_SAMPLES;

  typedef enum logic [1:0] {StArmed, StCapture, StHoldoff} state_e;

  state_e            state_q;
  logic [CntW-1:0]   win_cnt_q;
  logic [CntW-1:0]   hold_cnt_q;
  logic [63:0]       ts_q;
  logic [63:0]       dl_ts_q   [PRE_SAMPLES];
  logic [15:0]       dl_data_q [PRE_SAMPLES];
  logic              dl_tag_q  [PRE_SAMPLES];

  logic trigger;
  logic produce;

  assign trigger = adc_valid_p && enable_p && (state_q == StArmed) && (adc_data_p > threshold_p);
  // The oldest delay-line entry is the word leaving the line on this valid edge.
  assign produce = adc_valid_p && (trigger || (state_q == StCapture))
                   && dl_tag_q[PRE_SAMPLES-1];
  assign busy_p  = (state_q != StArmed);

  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 64'd1;
    end
  end

  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < int'(PRE_SAMPLES); i++) begin
        dl_ts_q[i]   <= '0;
        dl_data_q[i] <= '0;
        dl_tag_q[i]  <= 1'b0;
      end
    end else if (adc_valid_p) begin
      dl_ts_q[0]   <= ts_q;
      dl_data_q[0] <= adc_data_p;
      dl_tag_q[0]  <= 1'b1;
      for (int i = 1; i < int'(PRE_SAMPLES); i++) begin
        dl_ts_q[i]   <= dl_ts_q[i-1];
        dl_data_q[i] <= dl_data_q[i-1];
        dl_tag_q[i]  <= dl_tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      state_q          <= StArmed;
      win_cnt_q        <= '0;
      hold_cnt_q       <= '0;
      event_count_p    <= '0;
      drop_count_p     <= '0;
      overflow_p       <= 1'b0;
      fifo_adc_wr_en_p <= 1'b0;
      fifo_adc_din_p   <= '0;
    end else begin
      fifo_adc_wr_en_p <= 1'b0;
      if (produce) begin
        if (fifo_adc_full_p) begin
          overflow_p <= 1'b1;
          if (drop_count_p != 16'hFFFF) begin
            drop_count_p <= drop_count_p + 16'd1;
          end
        end else begin
          fifo_adc_wr_en_p <= 1'b1;
          fifo_adc_din_p   <= {dl_ts_q[PRE_SAMPLES-1], dl_data_q[PRE_SAMPLES-1]};
        end
      end

      case (state_q)
        StArmed: begin
          if (trigger) begin
            event_count_p <= event_count_p + 16'd1;
            // The trigger edge itself consumes the first window slot.
            win_cnt_q     <= CntW'(WinLen - 1);
            state_q       <= StCapture;
          end
        end
        StCapture: begin
          if (adc_valid_p) begin
            win_cnt_q <= win_cnt_q - 1'b1;
            if (win_cnt_q == CntW'(1)) begin
              if (HOLDOFF_SAMPLES == 0) begin
                state_q <= StArmed;
              end else begin
                hold_cnt_q <= CntW'(HOLDOFF_SAMPLES);
                state_q    <= StHoldoff;
              end
            end
          end
        end
        StHoldoff: begin
          if (adc_valid_p) begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
            if (hold_cnt_q == CntW'(1)) begin
              state_q <= StArmed;
            end
          end
        end
        default: state_q <= StArmed;
      endcase
    end
  end

endmodule
